// File: rtl/conv_sequencer.sv
// conv_sequencer: address/control sequencer for one valid-mode K x K convolution
// pass over a single-channel IMG_W x IMG_H tile. For each output pixel (raster
// order) it issues K*K MAC taps, waits out the MAC pipeline, then offers the
// result to the output buffer with a valid/ready handshake.
module conv_sequencer #(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int K       = 3,
  parameter int MAC_LAT = 1,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] in_addr,
  output logic [7:0]        w_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  localparam logic [7:0]        K_M1    = 8'(K - 1);
  localparam logic [7:0]        K_8     = 8'(K);
  localparam logic [ADDR_W-1:0] OW_M1   = ADDR_W'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] OH_M1   = ADDR_W'(OUT_H - 1);
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] OUT_W_A = ADDR_W'(OUT_W);
  localparam logic [LAT_W-1:0]  LAT_M1  = LAT_W'(MAC_LAT - 1);

  // Reject geometries the address arithmetic cannot represent.
  if (K < 1 || IMG_W < K || IMG_H < K || MAC_LAT < 1 || K * K > 256 ||
      ADDR_W < 1 || ADDR_W > 30 || (IMG_W * IMG_H - 1) >= (1 << ADDR_W)) begin : g_param_check
    $error("conv_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ox_q, ox_d;
  logic [ADDR_W-1:0]   oy_q, oy_d;
  logic [7:0]          kx_q, kx_d;
  logic [7:0]          ky_q, ky_d;
  logic [LAT_W-1:0]    lat_q, lat_d;

  logic [ADDR_W-1:0]   tap_row;
  logic [ADDR_W-1:0]   tap_col;

  // State and counter registers; reset aborts any pass in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ox_q    <= '0;
      oy_q    <= '0;
      kx_q    <= '0;
      ky_q    <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      lat_q   <= lat_d;
    end
  end

  // Next-state and counter stepping: taps inner, output pixels outer.
  always_comb begin
    state_d = state_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MAC;
          ox_d    = '0;
          oy_d    = '0;
          kx_d    = '0;
          ky_d    = '0;
        end
      end
      S_MAC: begin
        if (kx_q == K_M1) begin
          kx_d = '0;
          if (ky_q == K_M1) begin
            ky_d    = '0;
            lat_d   = '0;
            state_d = S_DRAIN;
          end else begin
            ky_d = ky_q + 8'd1;
          end
        end else begin
          kx_d = kx_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (lat_q == LAT_M1) begin
          state_d = S_WRITE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_WRITE: begin
        if (out_ready) begin
          if (ox_q == OW_M1 && oy_q == OH_M1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_MAC;
            if (ox_q == OW_M1) begin
              ox_d = '0;
              oy_d = oy_q + ADDR_W'(1);
            end else begin
              ox_d = ox_q + ADDR_W'(1);
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ox_d    = '0;
        oy_d    = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode; addresses are only driven in the state that uses them.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    out_valid = 1'b0;
    in_addr   = '0;
    w_addr    = '0;
    out_addr  = '0;
    tap_row   = oy_q + ADDR_W'(ky_q);
    tap_col   = ox_q + ADDR_W'(kx_q);
    case (state_q)
      S_MAC: begin
        busy    = 1'b1;
        mac_en  = 1'b1;
        mac_clr = (kx_q == 8'd0) && (ky_q == 8'd0);
        in_addr = tap_row * IMG_W_A + tap_col;
        w_addr  = ky_q * K_8 + kx_q;
      end
      S_DRAIN: begin
        busy = 1'b1;
      end
      S_WRITE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_addr  = oy_q * OUT_W_A + ox_q;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: a 4x4/K=3/MAC_LAT=1 instance and a 2x2/K=1/MAC_LAT=2
// instance. A directed trace table covers the first two pixels cycle by cycle;
// a loop-nest reference model then walks whole passes with random backpressure
// and random start noise, plus backpressure, abort and back-to-back sequences.
module tb_conv_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic out_ready;
  logic start_drv;
  bit   sel;

  logic start_a, start_b;
  assign start_a = start_drv & ~sel;
  assign start_b = start_drv & sel;

  logic       busy_a, done_a, clr_a, en_a, valid_a;
  logic [7:0] in_a, w_a, out_a;
  logic       busy_b, done_b, clr_b, en_b, valid_b;
  logic [7:0] in_b, w_b, out_b;

  conv_sequencer #(.IMG_W(4), .IMG_H(4), .K(3), .MAC_LAT(1), .ADDR_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .in_addr(in_a), .w_addr(w_a), .mac_clr(clr_a), .mac_en(en_a),
    .out_valid(valid_a), .out_ready(out_ready), .out_addr(out_a)
  );

  conv_sequencer #(.IMG_W(2), .IMG_H(2), .K(1), .MAC_LAT(2), .ADDR_W(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .in_addr(in_b), .w_addr(w_b), .mac_clr(clr_b), .mac_en(en_b),
    .out_valid(valid_b), .out_ready(out_ready), .out_addr(out_b)
  );

  // Observed vector: busy done mac_en mac_clr out_valid in_addr w_addr out_addr
  logic [28:0] vec_a, vec_b, obs;
  assign vec_a = {busy_a, done_a, en_a, clr_a, valid_a, in_a, w_a, out_a};
  assign vec_b = {busy_b, done_b, en_b, clr_b, valid_b, in_b, w_b, out_b};
  assign obs   = sel ? vec_b : vec_a;

  localparam logic [28:0] M_ALL = 29'h1FFF_FFFF;
  localparam logic [28:0] M_CTL = 29'h1F00_0000;
  localparam logic [28:0] M_MAC = 29'h1FFF_FF00;
  localparam logic [28:0] M_WR  = 29'h1F00_00FF;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit          start;
    bit          ready;
    logic [28:0] exp;
    logic [28:0] mask;
  } row_t;

  function automatic logic [28:0] vec(bit b, bit d, bit e, bit c, bit v,
                                      int ia, int wa, int oa);
    return {b, d, e, c, v, 8'(ia), 8'(wa), 8'(oa)};
  endfunction

  task automatic check(input string name, input logic [28:0] exp, input logic [28:0] mask);
    n_checks++;
    if ((obs & mask) === (exp & mask)) n_pass++;
    else $display("FAIL %s: got %h required %h (mask %h) at %0t", name, obs & mask, exp & mask, mask, $time);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d at %0t", name, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise(input bit hold_start);
    start_drv = hold_start ? 1'b1 : 1'($urandom % 2);
    out_ready = 1'($urandom % 2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start_drv = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Reference model: a pass is nested loops over output pixels and kernel taps.
  // ready_mode 0: ready always 1; 1: random ready; 2: first WRITE stalled 5 cycles.
  task automatic run_pass(input int w, input int h, input int k, input int lat,
                          input int ready_mode, input bit hold_start,
                          input int abort_pix, input string tag);
    int ow, oh, busy_seen, stalls, pix, c;
    bit r;
    ow = w - k + 1;
    oh = h - k + 1;
    busy_seen = 0;
    stalls = 0;
    pix = 0;
    start_drv = 1'b1;
    out_ready = 1'($urandom % 2);
    step();
    for (int oy = 0; oy < oh; oy++) begin
      for (int ox = 0; ox < ow; ox++) begin
        for (int ky = 0; ky < k; ky++) begin
          for (int kx = 0; kx < k; kx++) begin
            if (pix == abort_pix && ky * k + kx == 1) begin
              reset = 1'b1;
              start_drv = 1'b0;
              step();
              reset = 1'b0;
              check("abort_idle", '0, M_ALL);
              for (int i = 0; i < 4; i++) begin
                step();
                check("abort_no_done", '0, M_ALL);
              end
              $display("pass %s: aborted at pixel %0d", tag, pix);
              return;
            end
            busy_seen += int'(obs[28]);
            check("mac", vec(1, 0, 1, (kx == 0 && ky == 0), 0,
                             (oy + ky) * w + ox + kx, ky * k + kx, 0), M_MAC);
            noise(hold_start);
            step();
          end
        end
        for (int l = 0; l < lat; l++) begin
          busy_seen += int'(obs[28]);
          check("drain", vec(1, 0, 0, 0, 0, 0, 0, 0), M_CTL);
          noise(hold_start);
          step();
        end
        c = 0;
        do begin
          busy_seen += int'(obs[28]);
          check("write", vec(1, 0, 0, 0, 1, 0, 0, oy * ow + ox), M_WR);
          case (ready_mode)
            0:       r = 1'b1;
            1:       r = ($urandom % 3) != 0;
            default: r = (pix == 0) ? (c >= 5) : 1'b1;
          endcase
          if (c >= 100) r = 1'b1;
          out_ready = r;
          start_drv = hold_start ? 1'b1 : 1'($urandom % 2);
          step();
          c++;
        end while (!r);
        stalls += c - 1;
        pix++;
      end
    end
    check("done", vec(0, 1, 0, 0, 0, 0, 0, 0), M_CTL);
    noise(hold_start);
    step();
    check_int("busy_cycles", busy_seen, ow * oh * (k * k + lat + 1) + stalls);
    check("idle_after", '0, M_ALL);
    if (!hold_start) start_drv = 1'b0;
    $display("pass %s: %0d writes, %0d busy cycles, %0d stall cycles", tag, pix, busy_seen, stalls);
  endtask

  row_t rows[22];
  int   p0[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int   p1[9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};

  initial begin
    sel = 1'b0;
    reset = 1'b1;
    start_drv = 1'b0;
    out_ready = 1'b0;

    // Directed trace for the 4x4 instance: pixel 0, drain, stalled write, pixel 1.
    rows[0]  = '{0, 0, '0, M_ALL};
    for (int t = 0; t < 9; t++)
      rows[1 + t] = '{(t == 0) | (t % 2 == 1), 1'(t % 2),
                      vec(1, 0, 1, t == 0, 0, p0[t], t, 0), M_MAC};
    rows[10] = '{0, 1, vec(1, 0, 0, 0, 0, 0, 0, 0), M_CTL};
    rows[11] = '{0, 0, vec(1, 0, 0, 0, 1, 0, 0, 0), M_WR};
    rows[12] = '{1, 0, vec(1, 0, 0, 0, 1, 0, 0, 0), M_WR};
    for (int t = 0; t < 9; t++)
      rows[13 + t] = '{1'(t % 2), 1'((t + 1) % 2),
                       vec(1, 0, 1, t == 0, 0, p1[t], t, 0), M_MAC};
    rows[13].ready = 1'b1;

    do_reset();
    check("reset_idle", '0, M_ALL);

    for (int i = 0; i < 22; i++) begin
      start_drv = rows[i].start;
      out_ready = rows[i].ready;
      step();
      check($sformatf("table_row%0d", i), rows[i].exp, rows[i].mask);
      $display("row %0d: start=%0b ready=%0b obs=%h", i, rows[i].start, rows[i].ready, obs);
    end

    do_reset();
    check("reset_idle2", '0, M_ALL);
    run_pass(4, 4, 3, 1, 0, 1'b0, -1, "basic");
    run_pass(4, 4, 3, 1, 2, 1'b0, -1, "backpressure");
    run_pass(4, 4, 3, 1, 0, 1'b0, 2, "abort");
    run_pass(4, 4, 3, 1, 0, 1'b0, -1, "after_abort");
    run_pass(4, 4, 3, 1, 1, 1'b0, -1, "start_noise");
    for (int i = 0; i < 3; i++) begin
      step();
      check("stay_idle", '0, M_ALL);
    end
    run_pass(4, 4, 3, 1, 0, 1'b1, -1, "b2b_1");
    run_pass(4, 4, 3, 1, 1, 1'b1, -1, "b2b_2");
    run_pass(4, 4, 3, 1, 0, 1'b0, -1, "b2b_3");
    for (int i = 0; i < 4; i++) run_pass(4, 4, 3, 1, 1, 1'b0, -1, "random");

    sel = 1'b1;
    do_reset();
    check("reset_idle_k1", '0, M_ALL);
    run_pass(2, 2, 1, 2, 0, 1'b0, -1, "k1_basic");
    run_pass(2, 2, 1, 2, 1, 1'b0, -1, "k1_random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
